// File: rtl/buffer_write_arbiter_if.sv
// Bundle of the producer-side and buffer-side signals around buffer_write_arbiter.
//   req/req_data/req_last : from the NUM_REQ producers (one slice per producer)
//   grant                 : one-hot word-accepted strobe back to the producers
//   buf_wr_en/buf_data    : write strobe and word into the buffer's wr_en/data_in
//   buf_full              : buffer full flag, the only backpressure source
//   active_id/busy        : current/last burst owner and "burst in progress" status
// The slave modport is the arbiter's view; master is the environment's view.
interface buffer_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            grant;
    logic                          buf_wr_en;
    logic [DATA_WIDTH-1:0]         buf_data;
    logic                          buf_full;
    logic [ID_W-1:0]               active_id;
    logic                          busy;

    modport slave (
        input  req, req_data, req_last, buf_full,
        output grant, buf_wr_en, buf_data, active_id, busy
    );

    modport master (
        output req, req_data, req_last, buf_full,
        input  grant, buf_wr_en, buf_data, active_id, busy
    );
endinterface

// File: rtl/buffer_write_arbiter.sv
// Round-robin arbiter sharing one buffer write port between NUM_REQ producers.
// A winner owns the port for a burst of up to MAX_BURST words, or until it
// flags req_last, or until it drops req. Every burst is followed by one IDLE
// arbitration cycle, after which the search restarts just above the last owner.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset; no write happens in any reset cycle
//   bus  : buffer_write_arbiter_if.slave (requests in, grant/buffer write out)
module buffer_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    buffer_write_arbiter_if.slave  bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t            state_q,     state_d;
    logic [ID_W-1:0]   owner_q,     owner_d;
    logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;

    logic [DATA_WIDTH-1:0] slice [NUM_REQ];
    logic                  sel_found;
    logic [ID_W-1:0]       sel_idx;
    logic                  accept;
    logic [CNT_W-1:0]      cnt_inc;
    logic [ID_W-1:0]       owner_next;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign slice[gi]     = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign bus.grant[gi] = accept && (owner_q == ID_W'(gi));
        end
    endgenerate

    // Rotating priority search: walk offsets from high to low so the
    // requester closest to rr_ptr (offset 0 first) is the last assignment.
    always_comb begin
        int idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (bus.req[ID_W'(idx)]) begin
                sel_found = 1'b1;
                sel_idx   = ID_W'(idx);
            end
        end
    end

    // Reset gates the write path so a burst interrupted by reset can never
    // emit a word while the registered state is still XFER.
    assign accept     = (state_q == XFER) && bus.req[owner_q] && !bus.buf_full && !rst;
    assign cnt_inc    = burst_cnt_q + CNT_W'(1);
    assign owner_next = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    owner_d     = sel_idx;
                    burst_cnt_d = '0;
                    state_d     = XFER;
                end
            end
            XFER: begin
                if (!bus.req[owner_q]) begin
                    // Owner went quiet between words: give the port up.
                    state_d  = IDLE;
                    rr_ptr_d = owner_next;
                end else if (accept) begin
                    burst_cnt_d = cnt_inc;
                    if (bus.req_last[owner_q] || (cnt_inc == CNT_W'(MAX_BURST))) begin
                        state_d  = IDLE;
                        rr_ptr_d = owner_next;
                    end
                end
                // buf_full with req held: everything stays, owner keeps the port.
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign bus.buf_wr_en = accept;
    assign bus.buf_data  = accept ? slice[owner_q] : '0;
    assign bus.busy      = (state_q == XFER) && !rst;
    assign bus.active_id = rst ? '0 : owner_q;
endmodule

// File: tb/tb_buffer_write_arbiter.sv
module tb_buffer_write_arbiter;
    logic clk;
    logic rst;

    buffer_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(16)) bus ();

    buffer_write_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(16), .MAX_BURST(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  last;
        logic        full;
        logic [63:0] data;
        logic [3:0]  eg;
        logic        ewr;
        logic [15:0] ed;
        logic        ebusy;
        logic [1:0]  eid;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   vnum   = 0;

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                       input logic f, input logic [63:0] d, input logic [3:0] eg,
                       input logic ewr, input logic [15:0] ed, input logic eb,
                       input logic [1:0] eid);
        vec_t v;
        v.rst = r; v.req = rq; v.last = ls; v.full = f; v.data = d;
        v.eg = eg; v.ewr = ewr; v.ed = ed; v.ebusy = eb; v.eid = eid;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec %0d %s: got %h expected %h", vnum, name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, compare on the falling edge.
    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        rst          = v.rst;
        bus.req      = v.req;
        bus.req_last = v.last;
        bus.buf_full = v.full;
        bus.req_data = v.data;
        @(negedge clk);
        $display("vec %0d rst=%b req=%b last=%b full=%b -> grant=%b wr=%b data=%h busy=%b id=%0d",
                 vnum, v.rst, v.req, v.last, v.full, bus.grant, bus.buf_wr_en,
                 bus.buf_data, bus.busy, bus.active_id);
        check("grant",     16'(bus.grant),     16'(v.eg));
        check("buf_wr_en", 16'(bus.buf_wr_en), 16'(v.ewr));
        check("buf_data",  bus.buf_data,       v.ed);
        check("busy",      16'(bus.busy),      16'(v.ebusy));
        check("active_id", 16'(bus.active_id), 16'(v.eid));
        vnum++;
    endtask

    localparam logic [63:0] D0  = 64'h4000_3000_2000_1000;
    localparam logic [63:0] DRR = 64'hC003_C002_C001_C000;
    localparam logic [63:0] D6  = 64'h6003_6002_6001_6000;

    initial begin
        vec_t v;
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_last = '0;
        bus.buf_full = 1'b0;
        bus.req_data = '0;

        // Reset with all requesting, then requester 0 wins first.
        for (int i = 0; i < 3; i++)
            add(1, 4'hF, 4'h0, 0, D0, 4'h0, 0, 16'h0000, 0, 0);
        add(0, 4'hF, 4'hF, 0, D0, 4'h0, 0, 16'h0000, 0, 0);
        add(0, 4'hF, 4'hF, 0, D0, 4'h1, 1, 16'h1000, 1, 0);
        add(0, 4'h0, 4'h0, 0, D0, 4'h0, 0, 16'h0000, 0, 0);
        // Single packet from requester 1: A1, A2, A3(last).
        add(0, 4'h2, 4'h0, 0, 64'h4000_3000_00A1_1000, 4'h0, 0, 16'h0000, 0, 0);
        add(0, 4'h2, 4'h0, 0, 64'h4000_3000_00A1_1000, 4'h2, 1, 16'h00A1, 1, 1);
        add(0, 4'h2, 4'h0, 0, 64'h4000_3000_00A2_1000, 4'h2, 1, 16'h00A2, 1, 1);
        add(0, 4'h2, 4'h2, 0, 64'h4000_3000_00A3_1000, 4'h2, 1, 16'h00A3, 1, 1);
        add(0, 4'h0, 4'h0, 0, D0, 4'h0, 0, 16'h0000, 0, 1);
        // Early drop: requester 2 drops after one word, requester 3 waits.
        add(0, 4'hC, 4'h0, 0, 64'h0B03_0B02_2000_1000, 4'h0, 0, 16'h0000, 0, 1);
        add(0, 4'hC, 4'h0, 0, 64'h0B03_0B02_2000_1000, 4'h4, 1, 16'h0B02, 1, 2);
        add(0, 4'h8, 4'h0, 0, 64'h0B03_0B02_2000_1000, 4'h0, 0, 16'h0000, 1, 2);
        add(0, 4'h8, 4'h0, 0, 64'h0B03_0B02_2000_1000, 4'h0, 0, 16'h0000, 0, 2);
        add(0, 4'h8, 4'h8, 0, 64'h0B03_0B02_2000_1000, 4'h8, 1, 16'h0B03, 1, 3);
        add(0, 4'h0, 4'h0, 0, D0, 4'h0, 0, 16'h0000, 0, 3);
        // Backpressure on requester 0: full for two cycles after word 2;
        // word 4 carries last as well, which must give a single release.
        add(0, 4'h1, 4'h0, 0, 64'h4000_3000_2000_0C01, 4'h0, 0, 16'h0000, 0, 3);
        add(0, 4'h1, 4'h0, 0, 64'h4000_3000_2000_0C01, 4'h1, 1, 16'h0C01, 1, 0);
        add(0, 4'h1, 4'h0, 0, 64'h4000_3000_2000_0C02, 4'h1, 1, 16'h0C02, 1, 0);
        add(0, 4'h1, 4'h0, 1, 64'h4000_3000_2000_0C03, 4'h0, 0, 16'h0000, 1, 0);
        add(0, 4'h1, 4'h0, 1, 64'h4000_3000_2000_0C03, 4'h0, 0, 16'h0000, 1, 0);
        add(0, 4'h1, 4'h0, 0, 64'h4000_3000_2000_0C03, 4'h1, 1, 16'h0C03, 1, 0);
        add(0, 4'h1, 4'h1, 0, 64'h4000_3000_2000_0C04, 4'h1, 1, 16'h0C04, 1, 0);
        add(0, 4'h0, 4'h0, 0, D0, 4'h0, 0, 16'h0000, 0, 0);

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i]);

        // Round robin: everyone requests, no last; 4-word bursts, one bubble each.
        v.last = 4'h0; v.full = 1'b0; v.data = DRR;
        v.rst = 1'b1; v.req = 4'hF; v.eg = 4'h0; v.ewr = 1'b0; v.ed = 16'h0;
        v.ebusy = 1'b0; v.eid = 2'd0;
        apply(v);
        apply(v);
        v.rst = 1'b0;
        apply(v);
        for (int b = 0; b < 5; b++) begin
            for (int w = 0; w < 4; w++) begin
                v.eg    = 4'(1 << (b % 4));
                v.ewr   = 1'b1;
                v.ed    = 16'hC000 | 16'(b % 4);
                v.ebusy = 1'b1;
                v.eid   = 2'(b % 4);
                apply(v);
            end
            v.eg = 4'h0; v.ewr = 1'b0; v.ed = 16'h0; v.ebusy = 1'b0;
            apply(v);
        end

        // Reset in the middle of requester 2's burst.
        v.data = D6;
        v.rst = 1'b1; v.req = 4'h0; v.eg = 4'h0; v.ewr = 1'b0; v.ed = 16'h0;
        v.ebusy = 1'b0; v.eid = 2'd0;
        apply(v);
        v.rst = 1'b0; v.req = 4'h4;
        apply(v);
        v.eg = 4'h4; v.ewr = 1'b1; v.ed = 16'h6002; v.ebusy = 1'b1; v.eid = 2'd2;
        apply(v);
        apply(v);
        v.rst = 1'b1; v.req = 4'hF; v.eg = 4'h0; v.ewr = 1'b0; v.ed = 16'h0;
        v.ebusy = 1'b0; v.eid = 2'd0;
        apply(v);
        v.rst = 1'b0;
        apply(v);
        v.req = 4'h1;
        for (int w = 0; w < 4; w++) begin
            v.eg = 4'h1; v.ewr = 1'b1; v.ed = 16'h6000; v.ebusy = 1'b1; v.eid = 2'd0;
            apply(v);
        end
        v.eg = 4'h0; v.ewr = 1'b0; v.ed = 16'h0; v.ebusy = 1'b0; v.eid = 2'd0;
        apply(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
